// File: rtl/bsr_block_sched_if.sv
// Descriptor stream from the block scheduler to the weight loader / array sequencer.
// valid/ready handshake; all payload fields are owned by the master and held while valid.
interface bsr_block_sched_if #(
    parameter int BRAM_ADDR_W = 10,
    parameter int WGT_ADDR_W  = 17
);
    logic                   valid;
    logic                   ready;
    logic [15:0]            row;
    logic [15:0]            col;
    logic [BRAM_ADDR_W-1:0] blk;
    logic [WGT_ADDR_W-1:0]  wgt_addr;
    logic                   last;

    modport master (output valid, row, col, blk, wgt_addr, last, input ready);
    modport slave  (input valid, row, col, blk, wgt_addr, last, output ready);
endinterface

// File: rtl/bsr_block_sched.sv
// Walks row_ptr/col_idx BRAMs and emits one descriptor per non-zero block; first valid 7 edges after start,
// then 3 cycles per block and 3 per row change. Descriptor is held until ready; row_ptr is checked on the way.
module bsr_block_sched #(
    parameter int BRAM_ADDR_W = 10,
    parameter int WGT_ADDR_W  = 17,
    parameter int BLOCK_BYTES = 200
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [31:0]            num_rows,
    input  logic [31:0]            total_blocks,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic                   row_ptr_re,
    output logic [BRAM_ADDR_W-1:0] row_ptr_raddr,
    input  logic [31:0]            row_ptr_rdata,
    output logic                   col_idx_re,
    output logic [BRAM_ADDR_W-1:0] col_idx_raddr,
    input  logic [15:0]            col_idx_rdata,
    bsr_block_sched_if.master      desc
);
    typedef enum logic [3:0] {
        IDLE, RD_P0, WAIT_P0, CHK_ROW, RD_PN, WAIT_PN, RD_COL, WAIT_COL, EMIT, ERR, DONE_ST
    } state_t;

    state_t                state;
    logic [31:0]           nrows_q;
    logic [31:0]           total_q;
    logic [31:0]           r;
    logic [31:0]           k;
    logic [31:0]           prev;
    logic [31:0]           row_end;
    logic [WGT_ADDR_W-1:0] wgt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            nrows_q       <= '0;
            total_q       <= '0;
            r             <= '0;
            k             <= '0;
            prev          <= '0;
            row_end       <= '0;
            wgt           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            row_ptr_re    <= 1'b0;
            row_ptr_raddr <= '0;
            col_idx_re    <= 1'b0;
            col_idx_raddr <= '0;
            desc.valid    <= 1'b0;
            desc.row      <= '0;
            desc.col      <= '0;
            desc.blk      <= '0;
            desc.wgt_addr <= '0;
            desc.last     <= 1'b0;
        end else begin
            // Read enables are one-cycle pulses issued on entry to the RD_* states.
            row_ptr_re <= 1'b0;
            col_idx_re <= 1'b0;
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        nrows_q       <= num_rows;
                        total_q       <= total_blocks;
                        error         <= 1'b0;
                        busy          <= 1'b1;
                        r             <= '0;
                        k             <= '0;
                        prev          <= '0;
                        wgt           <= '0;
                        row_ptr_re    <= 1'b1;
                        row_ptr_raddr <= '0;
                        state         <= RD_P0;
                    end
                end
                RD_P0: state <= WAIT_P0;
                WAIT_P0: begin
                    if (row_ptr_rdata != 32'd0) begin
                        error <= 1'b1;
                        state <= ERR;
                    end else begin
                        prev  <= '0;
                        state <= CHK_ROW;
                    end
                end
                CHK_ROW: begin
                    if (r == nrows_q) begin
                        if (prev != total_q) begin
                            error <= 1'b1;
                            state <= ERR;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE_ST;
                        end
                    end else begin
                        row_ptr_re    <= 1'b1;
                        row_ptr_raddr <= BRAM_ADDR_W'(r + 32'd1);
                        state         <= RD_PN;
                    end
                end
                RD_PN: state <= WAIT_PN;
                WAIT_PN: begin
                    row_end <= row_ptr_rdata;
                    if (row_ptr_rdata < prev || row_ptr_rdata > total_q) begin
                        error <= 1'b1;
                        state <= ERR;
                    end else if (row_ptr_rdata == prev) begin
                        r     <= r + 32'd1;
                        state <= CHK_ROW;
                    end else begin
                        col_idx_re    <= 1'b1;
                        col_idx_raddr <= k[BRAM_ADDR_W-1:0];
                        state         <= RD_COL;
                    end
                end
                RD_COL: state <= WAIT_COL;
                WAIT_COL: begin
                    desc.valid    <= 1'b1;
                    desc.row      <= r[15:0];
                    desc.col      <= col_idx_rdata;
                    desc.blk      <= k[BRAM_ADDR_W-1:0];
                    desc.wgt_addr <= wgt;
                    desc.last     <= (k + 32'd1 == total_q);
                    state         <= EMIT;
                end
                EMIT: begin
                    if (desc.ready) begin
                        desc.valid <= 1'b0;
                        k          <= k + 32'd1;
                        wgt        <= wgt + WGT_ADDR_W'(BLOCK_BYTES);
                        prev       <= k + 32'd1;
                        if (k + 32'd1 == row_end) begin
                            r     <= r + 32'd1;
                            state <= CHK_ROW;
                        end else begin
                            col_idx_re    <= 1'b1;
                            col_idx_raddr <= BRAM_ADDR_W'(k + 32'd1);
                            state         <= RD_COL;
                        end
                    end
                end
                ERR: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE_ST;
                end
                DONE_ST: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (!start) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bsr_block_sched.sv
// Scoreboard bench for bsr_block_sched: expected descriptors are queued at stimulus time
// and compared at each handshake; BRAMs are modelled with 1-cycle read latency.
module tb_bsr_block_sched;
    localparam int AW = 10;
    localparam int WW = 17;

    typedef logic [63:0] pk_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic [31:0]   num_rows;
    logic [31:0]   total_blocks;
    logic          busy;
    logic          done;
    logic          error;
    logic          row_ptr_re;
    logic [AW-1:0] row_ptr_raddr;
    logic [31:0]   row_ptr_rdata;
    logic          col_idx_re;
    logic [AW-1:0] col_idx_raddr;
    logic [15:0]   col_idx_rdata;

    bsr_block_sched_if #(.BRAM_ADDR_W(AW), .WGT_ADDR_W(WW)) dif ();

    bsr_block_sched #(.BRAM_ADDR_W(AW), .WGT_ADDR_W(WW), .BLOCK_BYTES(200)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_rows     (num_rows),
        .total_blocks (total_blocks),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .row_ptr_re   (row_ptr_re),
        .row_ptr_raddr(row_ptr_raddr),
        .row_ptr_rdata(row_ptr_rdata),
        .col_idx_re   (col_idx_re),
        .col_idx_raddr(col_idx_raddr),
        .col_idx_rdata(col_idx_rdata),
        .desc         (dif)
    );

    logic [31:0] rp_mem [0:15];
    logic [15:0] ci_mem [0:15];

    always @(posedge clk) begin
        if (row_ptr_re) row_ptr_rdata <= rp_mem[row_ptr_raddr[3:0]];
        if (col_idx_re) col_idx_rdata <= ci_mem[col_idx_raddr[3:0]];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int  n_vec = 0;
    int  n_bad = 0;
    pk_t sb[$];
    int  hs_cyc[$];
    int  cyc = 0;
    bit  bp_mode = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic pk_t pk(input logic [15:0] row, input logic [15:0] col,
                               input logic [AW-1:0] blk, input logic [WW-1:0] addr,
                               input logic last);
        return {4'b0, row, col, blk, addr, last};
    endfunction

    // Handshake monitor and ready generator; runs on the falling edge.
    initial begin
        logic pv, pr, rst_d;
        pk_t  pf, cur;
        int   wait_cnt;
        pv = 1'b0; pr = 1'b0; rst_d = 1'b0; pf = '0; wait_cnt = 0;
        dif.ready = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            cur = pk(dif.row, dif.col, dif.blk, dif.wgt_addr, dif.last);
            if (pv && pr && !rst_d) begin
                hs_cyc.push_back(cyc);
                if (sb.size() == 0) check("sb_extra_desc", pf, '1);
                else check("desc", pf, sb.pop_front());
            end
            if (pv && !pr && !rst_d)
                check("hold", cur | {dif.valid, 63'b0}, pf | {1'b1, 63'b0});
            if (row_ptr_re || col_idx_re)
                check("one_read", {63'b0, row_ptr_re & col_idx_re}, 64'd0);
            if (!bp_mode) begin
                dif.ready = 1'b1;
            end else if (dif.valid) begin
                if (wait_cnt < 4) begin
                    dif.ready = 1'b0;
                    wait_cnt++;
                end else begin
                    dif.ready = 1'b1;
                end
            end else begin
                dif.ready = 1'b0;
                wait_cnt  = 0;
            end
            pv = dif.valid; pr = dif.ready; pf = cur; rst_d = rst;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_nominal();
        sb.push_back(pk(16'd0, 16'd5, 10'd0, 17'd0,   1'b0));
        sb.push_back(pk(16'd0, 16'd1, 10'd1, 17'd200, 1'b0));
        sb.push_back(pk(16'd2, 16'd7, 10'd2, 17'd400, 1'b1));
    endtask

    task automatic load_nominal();
        rp_mem[0] = 0; rp_mem[1] = 2; rp_mem[2] = 2; rp_mem[3] = 3;
        ci_mem[0] = 5; ci_mem[1] = 1; ci_mem[2] = 7;
    endtask

    task automatic start_run(input logic [31:0] nr, input logic [31:0] tot);
        num_rows     = nr;
        total_blocks = tot;
        hs_cyc.delete();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_wait(input string tag, input logic exp_err);
        for (int i = 0; i < 600 && !done; i++) @(negedge clk);
        check({tag, "_done"}, {63'b0, done}, 64'd1);
        step();
        check({tag, "_err"},  {63'b0, error}, {63'b0, exp_err});
        check({tag, "_busy"}, {63'b0, busy}, 64'd0);
        check({tag, "_left"}, sb.size(), 64'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, {58'b0, busy, done, error, row_ptr_re, col_idx_re, dif.valid}, 64'd0);
        check({tag, "_addr"}, {44'b0, row_ptr_raddr, col_idx_raddr}, 64'd0);
        check({tag, "_fields"}, pk(dif.row, dif.col, dif.blk, dif.wgt_addr, dif.last), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        rst = 1'b1; start = 1'b0; num_rows = '0; total_blocks = '0;
        for (int i = 0; i < 16; i++) begin
            rp_mem[i] = '0;
            ci_mem[i] = '0;
        end
        repeat (3) step();
        check_zero("reset");
        rst = 1'b0;
        step();

        // Nominal run with latency and throughput checks.
        load_nominal();
        push_nominal();
        start_run(3, 3);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!dif.valid && lat < 30);
        check("first_valid_lat", lat, 8);
        run_wait("nom", 1'b0);
        check("nom_hs_cnt", hs_cyc.size(), 3);
        if (hs_cyc.size() == 3) begin
            check("nom_gap_in_row", hs_cyc[1] - hs_cyc[0], 3);
            check("nom_gap_empty_row", hs_cyc[2] - hs_cyc[1], 9);
        end
        repeat (2) step();
        check("nom_done_clr", {63'b0, done}, 64'd0);

        // Backpressure, plus a start pulse while busy that must be ignored.
        bp_mode = 1'b1;
        push_nominal();
        start_run(3, 3);
        repeat (4) step();
        check("bp_busy", {63'b0, busy}, 64'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        run_wait("bp", 1'b0);
        bp_mode = 1'b0;
        repeat (2) step();

        // Corrupt row_ptr: row 0 claims 3 blocks, row 1 ends before it.
        rp_mem[1] = 3;
        sb.push_back(pk(16'd0, 16'd5, 10'd0, 17'd0,   1'b0));
        sb.push_back(pk(16'd0, 16'd1, 10'd1, 17'd200, 1'b0));
        sb.push_back(pk(16'd0, 16'd7, 10'd2, 17'd400, 1'b1));
        start_run(3, 3);
        run_wait("corrupt", 1'b1);
        repeat (2) step();

        // Empty matrix, then a bad trailing row_ptr entry.
        for (int i = 0; i < 16; i++) rp_mem[i] = '0;
        start_run(4, 0);
        run_wait("empty", 1'b0);
        repeat (2) step();
        rp_mem[4] = 1;
        start_run(4, 0);
        run_wait("empty_bad", 1'b1);
        repeat (2) step();

        // Reset while a descriptor is pending in EMIT.
        rp_mem[4] = 0;
        load_nominal();
        bp_mode = 1'b1;
        push_nominal();
        start_run(3, 3);
        for (int i = 0; i < 40 && !dif.valid; i++) @(negedge clk);
        check("rst_saw_valid", {63'b0, dif.valid}, 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        check_zero("midrst");
        rst = 1'b0;
        sb.delete();
        bp_mode = 1'b0;
        step();
        push_nominal();
        start_run(3, 3);
        run_wait("after_rst", 1'b0);
        repeat (2) step();

        // start held high after completion keeps the block in DONE_ST.
        push_nominal();
        num_rows = 3; total_blocks = 3;
        start = 1'b1;
        run_wait("hold", 1'b0);
        repeat (5) step();
        check("hold_done", {63'b0, done}, 64'd1);
        check("hold_no_rerun", sb.size(), 64'd0);
        start = 1'b0;
        repeat (2) step();
        check("hold_release_done", {63'b0, done}, 64'd0);
        check("hold_release_busy", {63'b0, busy}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
